// File: rtl/mul_pkg.sv
// Shared widths and accumulator state encoding for the multiplier datapath.
package mul_pkg;

   localparam int MUL_OP_W = 16;
   localparam int PROD_W   = 32;
   localparam int ACC_W    = 40;
   localparam int CNT_W    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } acc_state_e;

endpackage

// File: rtl/sat_add.sv
// Saturating adder: ACC_W-bit running sum plus zero-extended PROD_W-bit product.
module sat_add #(
   parameter int ACC_W  = 40,
   parameter int PROD_W = 32
) (
   input  logic [ACC_W-1:0]  a,
   input  logic [PROD_W-1:0] b,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic [ACC_W:0] wide;

   // One extra carry bit; a carry out clamps the result to all ones.
   always_comb begin
      wide = {1'b0, a} + (ACC_W + 1)'(b);
      ovf  = wide[ACC_W];
      sum  = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
   end

endmodule

// File: rtl/mul_accumulator.sv
// Block accumulator: sums LEN products received over valid/ready and holds the
// saturated sum with a sticky overflow flag until the consumer accepts it.
module mul_accumulator
   import mul_pkg::*;
#(
   parameter int PROD_W = mul_pkg::PROD_W,
   parameter int ACC_W  = mul_pkg::ACC_W,
   parameter int CNT_W  = mul_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [CNT_W-1:0]  len,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] product,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [ACC_W-1:0]  acc_sum,
   output logic              acc_ovf,
   output logic              busy
);

   acc_state_e        state;
   logic [ACC_W-1:0]  sum_q;
   logic              ovf_q;
   logic [CNT_W:0]    count;
   logic [CNT_W-1:0]  len_q;

   logic [CNT_W:0]    len_full;
   logic [CNT_W:0]    len_q_full;
   logic [CNT_W:0]    count_nxt;
   logic [ACC_W-1:0]  add_sum;
   logic              add_ovf;
   logic              accept;

   // len=0 encodes 2**CNT_W: the extra MSB is set exactly when the field is zero.
   always_comb begin
      len_full   = {(len == '0), len};
      len_q_full = {(len_q == '0), len_q};
      count_nxt  = count + 1'b1;
      accept     = prod_valid && prod_ready;
   end

   sat_add #(
      .ACC_W  (ACC_W),
      .PROD_W (PROD_W)
   ) u_sat_add (
      .a   (sum_q),
      .b   (product),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   assign acc_sum = sum_q;
   assign acc_ovf = ovf_q;

   // Block FSM with registered handshake/status outputs; clear overrides everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sum_q      <= '0;
         ovf_q      <= 1'b0;
         count      <= '0;
         len_q      <= '0;
         prod_ready <= 1'b1;
         acc_valid  <= 1'b0;
         busy       <= 1'b0;
      end else if (clear) begin
         state      <= IDLE;
         sum_q      <= '0;
         ovf_q      <= 1'b0;
         count      <= '0;
         prod_ready <= 1'b1;
         acc_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  len_q <= len;
                  sum_q <= ACC_W'(product);
                  ovf_q <= 1'b0;
                  count <= (CNT_W + 1)'(1);
                  busy  <= 1'b1;
                  if (len_full == (CNT_W + 1)'(1)) begin
                     state      <= HOLD;
                     prod_ready <= 1'b0;
                     acc_valid  <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  sum_q <= add_sum;
                  ovf_q <= ovf_q | add_ovf;
                  count <= count_nxt;
                  if (count_nxt == len_q_full) begin
                     state      <= HOLD;
                     prod_ready <= 1'b0;
                     acc_valid  <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (acc_ready) begin
                  state      <= IDLE;
                  sum_q      <= '0;
                  ovf_q      <= 1'b0;
                  count      <= '0;
                  prod_ready <= 1'b1;
                  acc_valid  <= 1'b0;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               prod_ready <= 1'b1;
               acc_valid  <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
